// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES datapath definitions: the GF(2^8) reduction constant, state and
// column typedefs, and the small field-multiply helpers used by MixColumns.
// No ports (package).
package aes_pkg;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  column_t;

  // Multiply by 2 in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by 3 in GF(2^8).
  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// mix_column_word
// Combinational forward MixColumns on a single 32-bit AES column.
// Ports:
//   col_in   [31:0]  column a0..a3, a0 in bits [31:24]
//   col_out  [31:0]  transformed column r0..r3, same byte layout
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] r0, r1, r2, r3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign r0 = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
  assign r1 = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
  assign r2 = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
  assign r3 = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);

  assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/mix_columns_iter.sv
// mix_columns_iter
// Iterative AES forward MixColumns. A 128-bit state is taken over a
// valid/ready handshake, transformed in place COLS_PER_CYCLE columns per
// clock, and held on the output handshake until consumed.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data valid
//   in_ready   engine can accept a state this cycle
//   in_data    input state, column c at [127-32c -: 32], row 0 in the MSB
//   out_valid  out_data holds a completed result
//   out_ready  consumer accepts out_data
//   out_data   MixColumns(in_data), same layout
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | empty, in_ready=1
// BUSY   | transforming columns col..col+COLS_PER_CYCLE-1 each cycle
// DONE   | result held in st, out_valid=1, in_ready follows out_ready
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // With 4 columns per cycle the step wraps to 0 and the last column
  // index is 0, so BUSY lasts exactly one cycle.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  logic [1:0] state, state_next;
  logic [1:0] col, col_next;
  state_t     st, st_next, st_mixed;

  column_t    st_cols  [4];
  logic [1:0] sel_idx  [COLS_PER_CYCLE];
  column_t    word_in  [COLS_PER_CYCLE];
  column_t    word_out [COLS_PER_CYCLE];

  for (genvar c = 0; c < 4; c++) begin : g_split
    assign st_cols[c] = st[127-32*c -: 32];
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign sel_idx[k] = col + 2'(k);
    assign word_in[k] = st_cols[sel_idx[k]];
    mix_column_word u_mix (
      .col_in  (word_in[k]),
      .col_out (word_out[k])
    );
  end

  // Write the transformed words back into their own column slots;
  // every other column keeps its current value.
  always_comb begin
    st_mixed = st;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        if (sel_idx[k] == 2'(c)) begin
          st_mixed[127-32*c -: 32] = word_out[k];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    col_next   = col;
    st_next    = st;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          st_next    = in_data;
          col_next   = 2'd0;
          state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        st_next  = st_mixed;
        col_next = col + COL_STEP;
        if (col == LAST_COL) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            st_next    = in_data;
            col_next   = 2'd0;
            state_next = S_BUSY;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      col   <= 2'd0;
      st    <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      st    <= st_next;
    end
  end

  assign out_valid = (state == S_DONE);
  // Consuming a result frees the engine in the same cycle.
  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_data  = st;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter
// Directed bench for mix_columns_iter with instances at 1, 2 and 4 columns
// per cycle, compared against a behavioural GF(2^8) reference.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_data1, out_data1;
  logic in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] in_data2, out_data2;
  logic in_valid4, in_ready4, out_valid4, out_ready4;
  logic [127:0] in_data4, out_data4;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] V_FIPS   = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E_FIPS   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_TWO    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E_TWO    = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V_ONES   = 128'h01010101_01010101_01010101_01010101;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_data(out_data4));

  // Generic shift-and-add field multiply.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
      r[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
      r[119-32*c -: 8] = gm(a0, 9) ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
      r[111-32*c -: 8] = gm(a0, 13) ^ gm(a1, 9) ^ gm(a2, 14) ^ gm(a3, 11);
      r[103-32*c -: 8] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9) ^ gm(a3, 14);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one state to an idle engine; returns #1 after the accepting edge.
  task automatic send1(input logic [127:0] d);
    in_data1 = d; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask
  task automatic send2(input logic [127:0] d);
    in_data2 = d; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask
  task automatic send4(input logic [127:0] d);
    in_data4 = d; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  // Count edges until out_valid; gives up at 20 so the caller's latency
  // comparison reports the timeout.
  task automatic wait_out1(output int n);
    n = 0;
    while (!out_valid1 && n < 20) begin @(posedge clk); #1; n++; end
  endtask
  task automatic wait_out2(output int n);
    n = 0;
    while (!out_valid2 && n < 20) begin @(posedge clk); #1; n++; end
  endtask
  task automatic wait_out4(output int n);
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain1();
    out_ready1 = 1'b1; @(posedge clk); #1; out_ready1 = 1'b0;
  endtask
  task automatic drain2();
    out_ready2 = 1'b1; @(posedge clk); #1; out_ready2 = 1'b0;
  endtask
  task automatic drain4();
    out_ready4 = 1'b1; @(posedge clk); #1; out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid1 = 0; out_ready1 = 0; in_data1 = '0;
    in_valid2 = 0; out_ready2 = 0; in_data2 = '0;
    in_valid4 = 0; out_ready4 = 0; in_data4 = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (out_valid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
    tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
    tests_run++; if (out_data1 !== 128'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data1); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_idle got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
    tests_run++; if (out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL reset_other_valid got %b %b want 0 0", out_valid2, out_valid4); end
  endtask

  task automatic test_fips();
    int n;
    send1(V_FIPS);
    tests_run++; if (in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL fips_busy_in_ready got %b want 0", in_ready1); end
    wait_out1(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL fips_latency got %0d want 4", n); end
    tests_run++; if (out_data1 !== E_FIPS) begin tests_failed++; $display("FAIL fips_data got %h want %h", out_data1, E_FIPS); end
    tests_run++; if (in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL fips_done_in_ready got %b want 0", in_ready1); end
    drain1();
    tests_run++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL fips_drain got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
  endtask

  task automatic test_widths();
    int n;
    send1(V_TWO);
    wait_out1(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL cpc1_latency got %0d want 4", n); end
    tests_run++; if (out_data1 !== E_TWO) begin tests_failed++; $display("FAIL cpc1_data got %h want %h", out_data1, E_TWO); end
    drain1();
    send2(V_TWO);
    wait_out2(n);
    tests_run++; if (n != 2) begin tests_failed++; $display("FAIL cpc2_latency got %0d want 2", n); end
    tests_run++; if (out_data2 !== E_TWO) begin tests_failed++; $display("FAIL cpc2_data got %h want %h", out_data2, E_TWO); end
    drain2();
    send2(V_FIPS);
    wait_out2(n);
    tests_run++; if (out_data2 !== E_FIPS) begin tests_failed++; $display("FAIL cpc2_fips got %h want %h", out_data2, E_FIPS); end
    drain2();
    send4(V_TWO);
    wait_out4(n);
    tests_run++; if (n != 1) begin tests_failed++; $display("FAIL cpc4_latency got %0d want 1", n); end
    tests_run++; if (out_data4 !== E_TWO) begin tests_failed++; $display("FAIL cpc4_data got %h want %h", out_data4, E_TWO); end
    drain4();
    send4(V_FIPS);
    wait_out4(n);
    tests_run++; if (out_data4 !== E_FIPS) begin tests_failed++; $display("FAIL cpc4_fips got %h want %h", out_data4, E_FIPS); end
    drain4();
  endtask

  task automatic test_backpressure();
    int n;
    send1(V_FIPS);
    wait_out1(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL bp_latency got %0d want 4", n); end
    // A pending input must not be taken while the result is unconsumed.
    in_data1 = V_TWO; in_valid1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || out_data1 !== E_FIPS) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d got v=%b r=%b d=%h want v=1 r=0 d=%h", i, out_valid1, in_ready1, out_data1, E_FIPS);
      end
    end
    out_ready1 = 1'b1;
    #1;
    tests_run++; if (in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_follow got %b want 1", in_ready1); end
    @(posedge clk); #1;
    out_ready1 = 1'b0; in_valid1 = 1'b0;
    tests_run++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL bp_accept got v=%b r=%b want v=0 r=0", out_valid1, in_ready1); end
    wait_out1(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL bp_next_latency got %0d want 4", n); end
    tests_run++; if (out_data1 !== E_TWO) begin tests_failed++; $display("FAIL bp_next_data got %h want %h", out_data1, E_TWO); end
    drain1();
  endtask

  task automatic test_back_to_back();
    logic [127:0] d [8];
    for (int i = 0; i < 8; i++) d[i] = rand_state();
    out_ready1 = 1'b1;
    in_data1 = d[0]; in_valid1 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) in_data1 = d[i+1];
      else in_valid1 = 1'b0;
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        tests_run++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_busy item %0d cycle %0d got v=%b r=%b want v=0 r=0", i, j, out_valid1, in_ready1);
        end
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid1 !== 1'b1 || in_ready1 !== 1'b1 || out_data1 !== mix_ref(d[i])) begin
        tests_failed++;
        $display("FAIL b2b_result item %0d got v=%b r=%b d=%h want v=1 r=1 d=%h", i, out_valid1, in_ready1, out_data1, mix_ref(d[i]));
      end
      @(posedge clk); #1;
    end
    out_ready1 = 1'b0;
    tests_run++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL b2b_end_idle got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
  endtask

  task automatic test_reset_mid_busy();
    int n;
    send1(V_FIPS);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++; if (in_ready1 !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_busy got %b want 0", in_ready1); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin tests_failed++; $display("FAIL rst_async got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
    tests_run++; if (out_data1 !== 128'h0) begin tests_failed++; $display("FAIL rst_async_data got %h want 0", out_data1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_valid1 !== 1'b0) begin tests_failed++; $display("FAIL rst_release_valid got %b want 0", out_valid1); end
    send1(V_ONES);
    wait_out1(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL rst_new_latency got %0d want 4", n); end
    tests_run++; if (out_data1 !== V_ONES) begin tests_failed++; $display("FAIL rst_new_data got %h want %h", out_data1, V_ONES); end
    drain1();
  endtask

  task automatic test_round_trip();
    int n;
    logic [127:0] s;
    for (int i = 0; i < 1000; i++) begin
      s = rand_state();
      send1(s);
      wait_out1(n);
      tests_run++;
      if (n != 4 || inv_ref(out_data1) !== s) begin
        tests_failed++;
        $display("FAIL round_trip item %0d got lat=%0d inv=%h want lat=4 inv=%h", i, n, inv_ref(out_data1), s);
      end
      drain1();
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_widths();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
